// File: rtl/sram22_ctrl_pkg.sv
// Shared definitions for the SRAM22 request controller: pointer-width helper,
// default geometry and the request bundle type.
package sram22_ctrl_pkg;

  // Minimum bits needed to index 'value' entries (at least 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r == 0) ? 1 : r;
  endfunction

  localparam int DATA_WIDTH_DEF  = 8;
  localparam int ADDR_WIDTH_DEF  = 12;
  localparam int WMASK_WIDTH_DEF = 1;
  localparam int RSP_DEPTH_DEF   = 2;
  localparam int PTR_W           = clog2(RSP_DEPTH_DEF);

  typedef struct packed {
    logic                       we;
    logic [WMASK_WIDTH_DEF-1:0] wmask;
    logic [ADDR_WIDTH_DEF-1:0]  addr;
    logic [DATA_WIDTH_DEF-1:0]  wdata;
  } sram_req_t;

endpackage

// File: rtl/sram22_rsp_fifo.sv
// Response skid FIFO: DEPTH x WIDTH, synchronous push/pop, occupancy count.
// When empty the output holds the last popped word (zero after reset).
module sram22_rsp_fifo
  import sram22_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  localparam int AW   = clog2(DEPTH),
  localparam int CW   = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] last_q;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_push = push && (count < CW'(DEPTH));
  assign do_pop  = pop && !empty;

  // Storage, pointers and occupancy; push and pop in one cycle keep the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      end
      if (do_pop) begin
        last_q <= mem[rd_ptr];
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head of queue when occupied, otherwise the most recently consumed word.
  always_comb begin
    dout = empty ? last_q : mem[rd_ptr];
  end

endmodule

// File: rtl/sram22_req_ctrl.sv
// Initiator-side front end for an SRAM22 single-port macro.
// Requests pass straight to the macro port; reads return in order through a
// credit-protected skid FIFO. Optional performance counters are built when
// SRAM22_REQ_CTRL_PERF_EN is defined.
module sram22_req_ctrl
  import sram22_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 12,
  parameter int WMASK_WIDTH = 1,
  parameter int RSP_DEPTH   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [WMASK_WIDTH-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_rdata,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
`ifdef SRAM22_REQ_CTRL_PERF_EN
  ,
  output logic [31:0]            perf_rd_cnt,
  output logic [31:0]            perf_wr_cnt,
  output logic [31:0]            perf_stall_cnt
`endif
);

  localparam int CW = clog2(RSP_DEPTH + 1);

  logic          rd_pending;
  logic          req_fire;
  logic          rsp_pop;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credits_used;

  assign req_fire   = req_valid && req_ready;
  assign rsp_pop    = rsp_valid && rsp_ready;
  assign sram_we    = req_fire && req_we;
  assign sram_wmask = req_wmask;
  assign sram_addr  = req_addr;
  assign sram_din   = req_wdata;
  assign rsp_valid  = (fifo_count != '0);

  // Outstanding slots: buffered + in-flight, minus the one leaving this cycle.
  // A pop only happens with a non-empty FIFO, so this cannot underflow.
  always_comb begin
    credits_used = {1'b0, fifo_count} + (CW + 1)'(rd_pending) - (CW + 1)'(rsp_pop);
    req_ready    = rst_n && (credits_used < (CW + 1)'(RSP_DEPTH));
  end

  // Marks that the macro's dout carries read data on the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_pending <= 1'b0;
    else        rd_pending <= req_fire && !req_we;
  end

  sram22_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_pending),
    .din   (sram_dout),
    .pop   (rsp_pop),
    .dout  (rsp_rdata),
    .count (fifo_count)
  );

`ifdef SRAM22_REQ_CTRL_PERF_EN
  // Free-running event counters; wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_rd_cnt    <= '0;
      perf_wr_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (req_fire && !req_we)      perf_rd_cnt    <= perf_rd_cnt + 32'd1;
      if (req_fire && req_we)       perf_wr_cnt    <= perf_wr_cnt + 32'd1;
      if (req_valid && !req_ready)  perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
